// File: rtl/spu_pkg.sv
// Shared SPU instruction-word definitions used by the loader and the decode stage.
package spu_pkg;
  localparam int INSTR_BYTES = 2;
  localparam int INSTR_W     = 8 * INSTR_BYTES;

  // Field layout of a 16-bit instruction word as seen by decode
  localparam int OPC_LSB = 12;
  localparam int OPC_W   = 4;
  localparam int RD_LSB  = 8;
  localparam int RD_W    = 4;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = 8;

  typedef logic [INSTR_W-1:0] instr_t;

  typedef struct packed {
    logic [OPC_W-1:0] opc;
    logic [RD_W-1:0]  rd;
    logic [IMM_W-1:0] imm;
  } instr_fields_t;

  function automatic logic [OPC_W-1:0] instr_opcode(input instr_t w);
    return w[OPC_LSB +: OPC_W];
  endfunction
endpackage

// File: rtl/spu_instr_loader_if.sv
// Valid/ready instruction handshake between the loader and the SPU execute stage.
interface spu_instr_loader_if #(parameter int W = spu_pkg::INSTR_W);
  logic [W-1:0] instr_data;
  logic         instr_valid;
  logic         instr_ready;

  modport master (output instr_data, output instr_valid, input  instr_ready);
  modport slave  (input  instr_data, input  instr_valid, output instr_ready);
endinterface

// File: rtl/spu_sync_fifo.sv
// First-word fall-through FIFO; the head word sits in its own register so the
// output is defined from reset and holds its last value once drained.
module spu_sync_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [W-1:0]     i_din,
  input  logic             i_pop,
  output logic [W-1:0]     o_dout,
  output logic [LVL_W-1:0] o_level,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [AW-1:0]    r_rd, r_wr;
  logic [LVL_W-1:0] r_lvl;
  logic [W-1:0]     r_head;

  logic             w_pop, w_push;
  logic [AW-1:0]    w_rd_n;
  logic [LVL_W-1:0] w_lvl_n;

  assign o_full  = (r_lvl == LVL_W'(DEPTH));
  assign o_empty = (r_lvl == '0);
  assign o_level = r_lvl;
  assign o_dout  = r_head;

  // A full FIFO still takes a word when the head leaves on the same edge
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign w_rd_n  = r_rd + AW'(w_pop);
  assign w_lvl_n = r_lvl + LVL_W'(w_push) - LVL_W'(w_pop);

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr] <= i_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd   <= '0;
      r_wr   <= '0;
      r_lvl  <= '0;
      r_head <= '0;
    end else if (i_flush) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_lvl <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      r_rd  <= w_rd_n;
      r_lvl <= w_lvl_n;
      // New head is the word being written only when it lands in the head slot
      if (w_lvl_n != '0)
        r_head <= (w_push && (w_rd_n == r_wr)) ? i_din : r_mem[w_rd_n];
    end
  end
endmodule

// File: rtl/spu_instr_loader.sv
// Strobe-driven byte assembler feeding a small instruction FIFO ahead of the SPU core.
module spu_instr_loader
  import spu_pkg::*;
#(
  parameter int INSTR_BYTES = spu_pkg::INSTR_BYTES,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [7:0]           in_byte,
  input  logic                 in_strobe,
  input  logic                 flush,
  spu_instr_loader_if.master   instr_if,
  output logic [LVL_W-1:0]     fifo_level,
  output logic                 busy,
  output logic                 overflow
);
  localparam int W     = 8 * INSTR_BYTES;
  localparam int CNT_W = $clog2(INSTR_BYTES);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic [CNT_W-1:0]       r_cnt;
  logic [W-9:0]           r_partial;
  logic                   r_ovf;

  logic         w_take, w_last, w_push, w_pop, w_full, w_empty;
  logic [W-1:0] w_word;

  // History tracks the synchroniser regardless of ena/flush so a held strobe never re-fires
  assign w_take = r_sync[SYNC_STAGES-1] & ~r_hist & ena;
  assign w_last = (r_cnt == CNT_W'(INSTR_BYTES - 1));
  assign w_word = {r_partial, in_byte};
  assign w_push = w_take & w_last & ~flush;
  assign w_pop  = ~w_empty & instr_if.instr_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync    <= '0;
      r_hist    <= 1'b0;
      r_cnt     <= '0;
      r_partial <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], in_strobe};
      r_hist <= r_sync[SYNC_STAGES-1];
      if (flush) begin
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else if (w_take) begin
        if (w_last) begin
          r_cnt <= '0;
          if (w_full && !w_pop) r_ovf <= 1'b1;
        end else begin
          r_cnt     <= r_cnt + CNT_W'(1);
          r_partial <= w_word[W-9:0];
        end
      end
    end
  end

  spu_sync_fifo #(.W(W), .DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (flush),
    .i_push  (w_push),
    .i_din   (w_word),
    .i_pop   (w_pop),
    .o_dout  (instr_if.instr_data),
    .o_level (fifo_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign instr_if.instr_valid = ~w_empty;
  assign busy                 = (r_cnt != '0);
  assign overflow             = r_ovf;
endmodule

// File: doc/spu_instr_loader.md
Name: spu_instr_loader

Overview:
Input stage directly upstream of the tt_umn_tinyspu core.
- Assembles multi-byte instruction words from the 8-bit dedicated input pins, one byte per rising edge of an external strobe.
- Buffers complete words in a small FIFO.
- Presents them to the SPU execute stage over a valid/ready handshake.
- Decouples slow external loading from core execution and reports fill level and overflow.

Parameters:
INSTR_BYTES  2  bytes per instruction word; word width W = 8*INSTR_BYTES
FIFO_DEPTH  4  instruction FIFO entries; power of two, >= 2
SYNC_STAGES  2  synchroniser flops on in_strobe; >= 2

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  design enable; strobes ignored while low
in_byte  in  8  byte presented on the input pins
in_strobe  in  1  asynchronous byte strobe; rising edge = take byte
flush  in  1  synchronous clear of FIFO, assembler and overflow
instr_data  out  W  word at FIFO head
instr_valid  out  1  FIFO not empty
instr_ready  in  1  core accepts head word when valid & ready
fifo_level  out  clog2(FIFO_DEPTH)+1  entries held, 0..FIFO_DEPTH
busy  out  1  partial word being assembled (byte count != 0)
overflow  out  1  sticky: a completed word was dropped

Behaviour:
- Reset (rst_n low, asynchronous):
  - Clears synchroniser, edge register, byte counter, partial register, FIFO pointers and overflow.
  - All outputs are 0, including instr_data.
- Strobe path:
  - in_strobe passes through SYNC_STAGES flops, then one history flop.
  - take = sync_out & ~hist & ena.
  - A strobe held high for many cycles yields exactly one take.
- Byte capture:
  - in_byte is sampled on the clock edge where take is true.
  - in_byte must be stable from strobe rise for SYNC_STAGES+1 cycles.
- Assembler: counter 0..INSTR_BYTES-1.
  - Byte order is big-endian: the first byte lands in instr_data[W-1:W-8].
  - On a take with count < INSTR_BYTES-1, the byte shifts into the partial register and count increments.
  - On a take with count = INSTR_BYTES-1, push {partial, in_byte} on the same edge and count returns to 0.
- Latency:
  - With instr_ready low, instr_valid is high after the (SYNC_STAGES+1)th rising clk edge at which in_strobe is sampled high for the last byte.
  - That is 3 edges for the defaults.
- FIFO:
  - First-word fall-through; instr_data is driven from the head register.
  - Pop = instr_valid & instr_ready.
  - Push is accepted if level < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Push and pop together leave the level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Level reaches exactly FIFO_DEPTH; there is no off-by-one reserve.
- Overflow:
  - A push with level = FIFO_DEPTH and no pop drops the word and sets overflow.
  - The byte counter still returns to 0.
  - FIFO contents and order are untouched.
  - overflow stays set until flush or reset.
- flush (synchronous, highest priority):
  - Next edge: level 0, count 0, overflow 0, instr_valid 0.
  - A concurrent take or pop is discarded.
  - The synchroniser is not cleared, so a strobe already high does not re-trigger.
- ena low:
  - Synchroniser and history keep tracking, so no spurious take when ena rises mid-strobe.
  - FIFO pops continue.
- instr_data holds its last value when the FIFO is empty; it is don't-care to the consumer but must not be X after reset.

Decomposition:
- Package spu_pkg:
  - INSTR_W and default INSTR_BYTES.
  - Opcode/operand field positions and widths shared with the SPU decode stage.
  - The instruction word typedef.
- Natural sub-module: spu_sync_fifo, a parameterised FWFT FIFO with push/pop/level/full/empty.
- Synchroniser, edge detect and assembler stay in spu_instr_loader.

Test Plan:
1. Reset: assert rst_n low mid-cycle -> immediately instr_valid=0, fifo_level=0, busy=0, overflow=0, instr_data=0.
2. Single word:
   - Stimulus: bytes 0xA5 then 0x3C with instr_ready=0.
   - After byte 1: busy=1.
   - 3 edges after the second strobe: instr_valid=1, instr_data=0xA53C, fifo_level=1, busy=0.
   - Then pulse ready for one cycle -> instr_valid=0, fifo_level=0.
3. Fill and overflow:
   - Stimulus: words 0x0001..0x0004 with ready=0 -> fifo_level=4; then word 0x0005 -> overflow=1, fifo_level=4.
   - Draining returns 0x0001,0x0002,0x0003,0x0004 in order; overflow stays 1.
4. Simultaneous push/pop at full:
   - Stimulus: FIFO holds 4 words; ready=1 on the exact edge the 5th word completes.
   - Response: overflow=0, fifo_level=4, and the last word drained is the 5th.
5. Flush and partial:
   - Stimulus: one byte 0x11 (busy=1), then pulse flush -> busy=0, fifo_level=0.
   - Then bytes 0x22,0x33 -> instr_data=0x2233.
   - Async reset between the two bytes also yields busy=0, with no word pushed.
6. Strobe qualification:
   - in_strobe held high 10 cycles -> exactly one byte taken.
   - Strobes with ena=0 -> busy stays 0.
   - Raising ena while strobe is high -> no take.
